// File: rtl/instr_sequencer_if.sv
// Instruction-source handshake bundle for instr_sequencer.
//   in_valid  : source -> sequencer, instruction valid (held until accepted)
//   in_ready  : sequencer -> source, sequencer is idle and can accept
//   instr     : source -> sequencer, {opcode, destination register}
//   flush     : source -> sequencer, synchronous abort of the current op
// master = instruction source, slave = sequencer.
interface instr_sequencer_if #(
    parameter int OPCODE_W  = 5,
    parameter int REG_SEL_W = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic [OPCODE_W+REG_SEL_W-1:0] instr;
    logic                          flush;

    modport master (output in_valid, output instr, output flush, input in_ready);
    modport slave  (input in_valid, input instr, input flush, output in_ready);
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction over a
// valid/ready handshake and steps it through decode, ALU execute,
// register writeback / store, and a retire cycle.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   src          : instruction handshake (instr_sequencer_if.slave)
//   alu_ce       : ALU enable, high for ALU_LATENCY cycles per ALU op
//   alu_opcode   : ALU operation, low 3 bits of the latched opcode
//   reg_ce       : one-hot register-file write enable (writeback cycle)
//   store_we     : store strobe
//   reg_sel      : latched destination register
//   done         : instruction retired pulse
//   illegal_op   : retired instruction had an illegal opcode
//   retired_cnt  : retired-instruction counter, present only when the
//                  macro INSTR_SEQ_RETIRE_CNT_EN is defined
//
// State table:
//   S_IDLE   | waiting for an instruction, in_ready=1
//   S_DECODE | classify latched opcode
//   S_EXEC   | ALU running, latency counter counting down
//   S_WB     | write result to reg_sel
//   S_STORE  | store strobe
//   S_DONE   | retire pulse, illegal_op if flagged
module instr_sequencer #(
    parameter int NUM_REGS    = 4,
    parameter int OPCODE_W    = 5,
    parameter int ALU_LATENCY = 2,
    parameter int CNT_W       = 16,
    localparam int REG_SEL_W  = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_sequencer_if.slave     src,
    output logic                 alu_ce,
    output logic [2:0]           alu_opcode,
    output logic [NUM_REGS-1:0]  reg_ce,
    output logic                 store_we,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 done,
    output logic                 illegal_op
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]     retired_cnt
`endif
);
    localparam int IW    = OPCODE_W + REG_SEL_W;
    localparam int LAT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    if (ALU_LATENCY < 1) begin : g_bad_latency
        $error("instr_sequencer: ALU_LATENCY must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("instr_sequencer: CNT_W must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_WB, S_STORE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       instr_q;
    logic [LAT_W-1:0]    lat_q;
    logic                illegal_q;
    logic [OPCODE_W-1:0] opcode;
    logic                is_alu, is_store, is_nop;

    assign opcode   = instr_q[IW-1:REG_SEL_W];
    assign is_nop   = (opcode == '0);
    assign is_alu   = !is_nop && (opcode <= OPCODE_W'(7));
    assign is_store = &opcode;

    // State register plus the datapath registers that follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            lat_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && src.in_valid && !src.flush)
                instr_q <= src.instr;
            if (src.flush)
                lat_q <= '0;
            else if (state_q == S_DECODE && is_alu)
                lat_q <= LAT_W'(ALU_LATENCY);
            else if (state_q == S_EXEC)
                lat_q <= lat_q - 1'b1;
            if (src.flush || state_q == S_DONE)
                illegal_q <= 1'b0;
            else if (state_q == S_DECODE && !is_alu && !is_store && !is_nop)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (src.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (src.in_valid) state_d = S_DECODE;
                S_DECODE: begin
                    if (is_alu)        state_d = S_EXEC;
                    else if (is_store) state_d = S_STORE;
                    else               state_d = S_DONE;
                end
                // counter holds the number of EXEC cycles still to run,
                // including the current one
                S_EXEC:   if (lat_q == LAT_W'(1)) state_d = S_WB;
                S_WB:     state_d = S_DONE;
                S_STORE:  state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        src.in_ready = (state_q == S_IDLE);
        alu_ce       = (state_q == S_EXEC);
        store_we     = (state_q == S_STORE);
        done         = (state_q == S_DONE);
        illegal_op   = (state_q == S_DONE) && illegal_q;
        reg_ce       = '0;
        if (state_q == S_WB)
            reg_ce[reg_sel] = 1'b1;
    end

    assign alu_opcode = opcode[2:0];
    assign reg_sel    = instr_q[REG_SEL_W-1:0];

`ifdef INSTR_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_cnt <= '0;
        else if (state_q == S_DONE)
            retired_cnt <= retired_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random traffic,
// every cycle compared against a schedule-based model of the sequencer.
module tb_instr_sequencer;
    localparam int NUM_REGS = 4;
    localparam int OPCODE_W = 5;
    localparam int RSW      = 2;
    localparam int LAT      = 2;
    localparam int CNT_W    = 4;
    localparam int IW       = OPCODE_W + RSW;
    localparam int STORE_OP = (1 << OPCODE_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_sequencer_if #(.OPCODE_W(OPCODE_W), .REG_SEL_W(RSW)) sif ();

    logic                alu_ce;
    logic [2:0]          alu_opcode;
    logic [NUM_REGS-1:0] reg_ce;
    logic                store_we;
    logic [RSW-1:0]      reg_sel;
    logic                done;
    logic                illegal_op;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0]    retired_cnt;
`endif

    instr_sequencer #(
        .NUM_REGS(NUM_REGS), .OPCODE_W(OPCODE_W),
        .ALU_LATENCY(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .src(sif),
        .alu_ce(alu_ce),
        .alu_opcode(alu_opcode),
        .reg_ce(reg_ce),
        .store_we(store_we),
        .reg_sel(reg_sel),
        .done(done),
        .illegal_op(illegal_op)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    // One entry per cycle of the expected output schedule.
    typedef struct packed {
        logic                alu;
        logic [NUM_REGS-1:0] rce;
        logic                st;
        logic                dn;
        logic                il;
    } cyc_t;

    cyc_t   sched[$];
    cyc_t   m_cur;
    logic   m_busy;
    int     m_instr;
    int     m_cnt;
    int     tests = 0;
    int     fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        m_cur   = '0;
        m_busy  = 1'b0;
        m_instr = 0;
        m_cnt   = 0;
    endtask

    // Expand an accepted instruction into its per-cycle output schedule.
    task automatic model_accept(input int ins);
        int   op, dst;
        cyc_t c;
        op      = ins >> RSW;
        dst     = ins % NUM_REGS;
        m_instr = ins;
        m_busy  = 1'b1;
        m_cur   = '0;             // decode cycle: nothing driven
        if (op >= 1 && op <= 7) begin
            for (int i = 0; i < LAT; i++) begin
                c = '0; c.alu = 1'b1; sched.push_back(c);
            end
            c = '0; c.rce = NUM_REGS'(1 << dst); sched.push_back(c);
            c = '0; c.dn = 1'b1; sched.push_back(c);
        end else if (op == STORE_OP) begin
            c = '0; c.st = 1'b1; sched.push_back(c);
            c = '0; c.dn = 1'b1; sched.push_back(c);
        end else begin
            c = '0; c.dn = 1'b1; c.il = (op != 0); sched.push_back(c);
        end
    endtask

    task automatic model_edge(input logic v, input int ins, input logic fl);
        if (m_busy) begin
            if (m_cur.dn) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (fl || sched.size() == 0) begin
                m_busy = 1'b0;
                m_cur  = '0;
                sched.delete();
            end else begin
                m_cur = sched.pop_front();
            end
        end else if (v && !fl) begin
            model_accept(ins);
        end
    endtask

    task automatic compare_all();
        chk("in_ready",   32'(sif.in_ready), 32'(!m_busy));
        chk("alu_ce",     32'(alu_ce),       32'(m_cur.alu));
        chk("reg_ce",     32'(reg_ce),       32'(m_cur.rce));
        chk("store_we",   32'(store_we),     32'(m_cur.st));
        chk("done",       32'(done),         32'(m_cur.dn));
        chk("illegal_op", 32'(illegal_op),   32'(m_cur.il));
        chk("alu_opcode", 32'(alu_opcode),   32'((m_instr >> RSW) % 8));
        chk("reg_sel",    32'(reg_sel),      32'(m_instr % NUM_REGS));
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
`endif
    endtask

    // Drive inputs 1 time unit after an edge, clock, then check.
    task automatic step(input logic v, input int ins, input logic fl);
        sif.in_valid = v;
        sif.instr    = IW'(ins);
        sif.flush    = fl;
        @(posedge clk);
        model_edge(v, ins, fl);
        #1;
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_busy; i++) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        int   cls, op, ins;
        logic v, fl;
        model_reset();
        sif.in_valid = 1'b0;
        sif.instr    = '0;
        sif.flush    = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("rst_in_ready", 32'(sif.in_ready), 32'd1);
        rst_n = 1'b1;
        step(1'b0, 0, 1'b0);
        chk("post_rst_outs", 32'({alu_ce, reg_ce, store_we, done, illegal_op, alu_opcode, reg_sel}), 32'd0);

        // ALU op 0x0E: opcode 3, destination 2
        step(1'b1, 'h0E, 1'b0);
        chk("alu_c1_ce", 32'(alu_ce), 32'd0);
        step(1'b0, 0, 1'b0);
        chk("alu_c2_ce", 32'(alu_ce), 32'd1);
        chk("alu_c2_op", 32'(alu_opcode), 32'd3);
        step(1'b0, 0, 1'b0);
        chk("alu_c3_ce", 32'(alu_ce), 32'd1);
        chk("alu_c3_rce", 32'(reg_ce), 32'd0);
        step(1'b0, 0, 1'b0);
        chk("alu_c4_rce", 32'(reg_ce), 32'h4);
        chk("alu_c4_ce", 32'(alu_ce), 32'd0);
        step(1'b0, 0, 1'b0);
        chk("alu_c5_done", 32'(done), 32'd1);
        chk("alu_c5_rdy", 32'(sif.in_ready), 32'd0);
        step(1'b0, 0, 1'b0);
        chk("alu_c6_rdy", 32'(sif.in_ready), 32'd1);
        chk("alu_c6_sel", 32'(reg_sel), 32'd2);

        // STORE 0x7D: opcode 31, destination 1
        step(1'b1, 'h7D, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("st_we", 32'(store_we), 32'd1);
        chk("st_sel", 32'(reg_sel), 32'd1);
        chk("st_alu_rce", 32'({alu_ce, reg_ce}), 32'd0);
        step(1'b0, 0, 1'b0);
        chk("st_done", 32'(done), 32'd1);
        step(1'b0, 0, 1'b0);

        // NOP then illegal opcode 8
        step(1'b1, 'h00, 1'b0);
        chk("nop_c1_done", 32'(done), 32'd0);
        step(1'b0, 0, 1'b0);
        chk("nop_done", 32'({done, illegal_op}), 32'b10);
        step(1'b0, 0, 1'b0);
        step(1'b1, 'h20, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("ill_done", 32'({done, illegal_op}), 32'b11);
        chk("ill_en", 32'({alu_ce, reg_ce, store_we}), 32'd0);
        step(1'b0, 0, 1'b0);

        // flush in the first EXEC cycle
        step(1'b1, 'h0E, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("fl_exec1", 32'(alu_ce), 32'd1);
        step(1'b0, 0, 1'b1);
        chk("fl_idle", 32'(sif.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 1'b0);
            chk("fl_no_wb_done", 32'({reg_ce, done}), 32'd0);
        end

        // flush wins over acceptance in IDLE
        step(1'b1, 'h0E, 1'b1);
        chk("fl_idle_rdy", 32'(sif.in_ready), 32'd1);
        step(1'b0, 0, 1'b0);
        chk("fl_idle_noacc", 32'(sif.in_ready), 32'd1);

        // asynchronous reset in the middle of EXEC
        step(1'b1, 'h0E, 1'b0);
        step(1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(sif.in_ready), 32'd1);
        chk("arst_outs", 32'({alu_ce, reg_ce, store_we, done, illegal_op, alu_opcode, reg_sel}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 0, 1'b0);

`ifdef INSTR_SEQ_RETIRE_CNT_EN
        step(1'b1, 'h0E, 1'b0); drain();
        step(1'b1, 'h00, 1'b0); drain();
        step(1'b1, 'h20, 1'b0); drain();
        step(1'b1, 'h7D, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("cnt_3", 32'(retired_cnt), 32'd3);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 'h00, 1'b0); drain();
        end
        chk("cnt_15", 32'(retired_cnt), 32'd15);
        step(1'b1, 'h00, 1'b0); drain();
        chk("cnt_wrap", 32'(retired_cnt), 32'd0);
`endif

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            cls = $urandom_range(0, 4);
            case (cls)
                0:       op = 0;
                1:       op = $urandom_range(1, 7);
                2:       op = STORE_OP;
                3:       op = $urandom_range(8, STORE_OP - 1);
                default: op = $urandom_range(0, STORE_OP);
            endcase
            ins = (op << RSW) | $urandom_range(0, NUM_REGS - 1);
            v   = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            step(v, ins, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
